// File: rtl/ll_window_acc.sv
`default_nettype none
// ============================================================================
// Module      : ll_window_acc
// Description : Sliding-window accumulator for a line-length sample stream.
//               It keeps the last WINDOW_SIZE samples and their running sum.
//               The sum is offered through a valid/ready handshake together
//               with a registered threshold-crossing flag.
// Revision    : 1.0 - initial release
// ============================================================================
module ll_window_acc #(
    parameter int INPUT_WIDTH = 64,
    parameter int WINDOW_SIZE = 32,
    parameter int ACC_WIDTH   = 69
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [INPUT_WIDTH-1:0] din,
    input  logic                   din_valid,
    input  logic                   clr,
    input  logic [ACC_WIDTH-1:0]   threshold,
    input  logic                   ready,
    output logic [ACC_WIDTH-1:0]   dout,
    output logic                   dout_valid,
    output logic                   over_thresh,
    output logic                   filled,
    output logic                   overrun
);

    localparam int c_PTR_W = $clog2(WINDOW_SIZE);
    localparam int c_CNT_W = c_PTR_W + 1;
    localparam int c_MAG_W = INPUT_WIDTH - 1;

    localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(WINDOW_SIZE - 1);
    localparam logic [c_CNT_W-1:0] c_CNT_FULL = c_CNT_W'(WINDOW_SIZE);
    localparam logic [c_PTR_W-1:0] c_PTR_ONE  = c_PTR_W'(1);

    localparam logic [0:0] c_ST_FILL = 1'b0;
    localparam logic [0:0] c_ST_RUN  = 1'b1;

    // Samples are stored as clamped magnitudes, so the sign bit is not kept.
    logic [c_MAG_W-1:0]   r_mem [WINDOW_SIZE];

    logic [0:0]           r_state;
    logic [c_PTR_W-1:0]   r_wr_ptr;
    logic [c_CNT_W-1:0]   r_cnt;
    logic [ACC_WIDTH-1:0] r_sum;
    logic [ACC_WIDTH-1:0] r_dout;
    logic                 r_dout_valid;
    logic                 r_over_thresh;
    logic                 r_filled;
    logic                 r_overrun;

    logic                 w_accept;
    logic                 w_load;
    logic [c_MAG_W-1:0]   w_mag;
    logic [c_MAG_W-1:0]   w_evict;
    logic [ACC_WIDTH-1:0] w_sum_next;

    assign w_accept = din_valid & ~clr;
    assign w_mag    = din[INPUT_WIDTH-1] ? '0 : din[c_MAG_W-1:0];

    // While filling, stale RAM contents must never leave the window sum.
    assign w_evict    = (r_state == c_ST_RUN) ? r_mem[r_wr_ptr] : '0;
    assign w_sum_next = r_sum + ACC_WIDTH'(w_mag) - ACC_WIDTH'(w_evict);

    // Loads happen on every accept that ends in RUN, including the fill edge.
    assign w_load = w_accept & ((r_state == c_ST_RUN) | (r_cnt == c_CNT_LAST));

    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_mem[r_wr_ptr] <= w_mag;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= c_ST_FILL;
            r_wr_ptr <= '0;
            r_cnt    <= '0;
            r_sum    <= '0;
        end else if (clr) begin
            r_state  <= c_ST_FILL;
            r_wr_ptr <= '0;
            r_cnt    <= '0;
            r_sum    <= '0;
        end else if (w_accept) begin
            r_sum    <= w_sum_next;
            r_wr_ptr <= r_wr_ptr + c_PTR_ONE;
            if (r_cnt != c_CNT_FULL) begin
                r_cnt <= r_cnt + c_CNT_W'(1);
            end
            if (r_cnt == c_CNT_LAST) begin
                r_state <= c_ST_RUN;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_dout        <= '0;
            r_dout_valid  <= 1'b0;
            r_over_thresh <= 1'b0;
            r_filled      <= 1'b0;
            r_overrun     <= 1'b0;
        end else if (clr) begin
            r_dout_valid  <= 1'b0;
            r_over_thresh <= 1'b0;
            r_filled      <= 1'b0;
            r_overrun     <= 1'b0;
        end else if (w_load) begin
            r_dout        <= w_sum_next;
            r_dout_valid  <= 1'b1;
            r_over_thresh <= (w_sum_next >= threshold);
            r_filled      <= 1'b1;
            if (r_dout_valid && !ready) begin
                r_overrun <= 1'b1;
            end
        end else if (r_dout_valid && ready) begin
            r_dout_valid  <= 1'b0;
            r_over_thresh <= 1'b0;
        end
    end

    assign dout        = r_dout;
    assign dout_valid  = r_dout_valid;
    assign over_thresh = r_over_thresh;
    assign filled      = r_filled;
    assign overrun     = r_overrun;

endmodule
`default_nettype wire

// File: tb/tb_ll_window_acc.sv
`default_nettype none
// ============================================================================
// Module      : tb_ll_window_acc
// Description : Directed self-checking bench for ll_window_acc (window of 4
//               plus a default-parameter instance for the full-scale case).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ll_window_acc;

    localparam int c_IW = 64;
    localparam int c_AW = 69;

    logic            clk;
    logic            rst;
    logic [c_IW-1:0] din;
    logic            din_valid;
    logic            clr;
    logic [c_AW-1:0] threshold;
    logic            ready;
    logic [c_AW-1:0] dout;
    logic            dout_valid;
    logic            over_thresh;
    logic            filled;
    logic            overrun;

    logic [c_IW-1:0] b_din;
    logic            b_din_valid;
    logic            b_clr;
    logic [c_AW-1:0] b_threshold;
    logic            b_ready;
    logic [c_AW-1:0] b_dout;
    logic            b_dout_valid;
    logic            b_over_thresh;
    logic            b_filled;
    logic            b_overrun;

    int n_checks;
    int n_errors;

    ll_window_acc #(
        .INPUT_WIDTH(c_IW),
        .WINDOW_SIZE(4),
        .ACC_WIDTH  (c_AW)
    ) u_dut (
        .clk        (clk),
        .rst        (rst),
        .din        (din),
        .din_valid  (din_valid),
        .clr        (clr),
        .threshold  (threshold),
        .ready      (ready),
        .dout       (dout),
        .dout_valid (dout_valid),
        .over_thresh(over_thresh),
        .filled     (filled),
        .overrun    (overrun)
    );

    ll_window_acc u_big (
        .clk        (clk),
        .rst        (rst),
        .din        (b_din),
        .din_valid  (b_din_valid),
        .clr        (b_clr),
        .threshold  (b_threshold),
        .ready      (b_ready),
        .dout       (b_dout),
        .dout_valid (b_dout_valid),
        .over_thresh(b_over_thresh),
        .filled     (b_filled),
        .overrun    (b_overrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [c_AW-1:0] act, input logic [c_AW-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    // One sample per call; the following idle cycle leaves outputs settled.
    task automatic send(input logic [c_IW-1:0] v);
        @(negedge clk);
        din       = v;
        din_valid = 1'b1;
        @(negedge clk);
        din_valid = 1'b0;
    endtask

    task automatic pulse_clr();
        @(negedge clk);
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
    endtask

    logic [c_AW-1:0] big_exp;

    initial begin
        n_checks    = 0;
        n_errors    = 0;
        rst         = 1'b1;
        din         = '0;
        din_valid   = 1'b0;
        clr         = 1'b0;
        threshold   = '0;
        ready       = 1'b0;
        b_din       = '0;
        b_din_valid = 1'b0;
        b_clr       = 1'b0;
        b_threshold = '0;
        b_ready     = 1'b0;

        repeat (2) @(negedge clk);
        chk("rst_dout",   dout, 0);
        chk("rst_valid",  69'(dout_valid), 0);
        chk("rst_filled", 69'(filled), 0);
        chk("rst_over",   69'(over_thresh), 0);
        chk("rst_overrun", 69'(overrun), 0);
        rst = 1'b0;

        // Fill and slide
        send(64'd1); send(64'd2); send(64'd3);
        chk("fill_valid_early", 69'(dout_valid), 0);
        chk("fill_filled_early", 69'(filled), 0);
        send(64'd4);
        chk("fill_dout10", dout, 10);
        chk("fill_valid", 69'(dout_valid), 1);
        chk("fill_filled", 69'(filled), 1);
        chk("fill_over_t0", 69'(over_thresh), 1);
        send(64'd5);
        chk("slide_dout14", dout, 14);
        send(64'd6);
        chk("slide_dout18", dout, 18);
        chk("slide_overrun", 69'(overrun), 1);

        // Asynchronous reset mid-window, between clock edges
        #2 rst = 1'b1;
        #1;
        chk("arst_dout",    dout, 0);
        chk("arst_valid",   69'(dout_valid), 0);
        chk("arst_filled",  69'(filled), 0);
        chk("arst_overrun", 69'(overrun), 0);
        @(negedge clk);
        rst = 1'b0;
        send(64'd1); send(64'd2); send(64'd3);
        chk("arst_refill_valid", 69'(dout_valid), 0);
        send(64'd4);
        chk("arst_refill_dout", dout, 10);
        chk("arst_refill_overrun", 69'(overrun), 0);

        // Backpressure
        pulse_clr();
        send(64'd1); send(64'd2); send(64'd3); send(64'd4);
        chk("bp_dout10", dout, 10);
        chk("bp_overrun0", 69'(overrun), 0);
        send(64'd5);
        chk("bp_dout14", dout, 14);
        chk("bp_overrun1", 69'(overrun), 1);
        @(negedge clk);
        ready = 1'b1;
        @(negedge clk);
        ready = 1'b0;
        chk("bp_valid_drop", 69'(dout_valid), 0);
        chk("bp_over_drop", 69'(over_thresh), 0);
        chk("bp_dout_held", dout, 14);
        chk("bp_overrun_sticky", 69'(overrun), 1);

        // Clear mid-RUN with a simultaneous sample
        send(64'd6);
        chk("clr_pre_dout", dout, 18);
        @(negedge clk);
        clr       = 1'b1;
        din       = 64'd100;
        din_valid = 1'b1;
        @(negedge clk);
        clr       = 1'b0;
        din_valid = 1'b0;
        chk("clr_valid", 69'(dout_valid), 0);
        chk("clr_filled", 69'(filled), 0);
        chk("clr_overrun", 69'(overrun), 0);
        chk("clr_dout_held", dout, 18);
        send(64'd7); send(64'd7); send(64'd7);
        chk("clr_refill_valid", 69'(dout_valid), 0);
        send(64'd7);
        chk("clr_dout28", dout, 28);

        // Negative clamp and threshold boundaries, consumer always ready
        pulse_clr();
        ready     = 1'b1;
        threshold = 69'd6;
        send(-64'sd5); send(64'd2); send(64'd2); send(64'd2);
        chk("neg_dout6", dout, 6);
        chk("neg_over_eq", 69'(over_thresh), 1);
        threshold = 69'd7;
        send(64'd2);
        chk("neg_dout8", dout, 8);
        chk("thr7_over", 69'(over_thresh), 1);
        threshold = 69'd9;
        send(64'd2);
        chk("thr9_dout", dout, 8);
        chk("thr9_over", 69'(over_thresh), 0);
        chk("ready_overrun0", 69'(overrun), 0);

        // Load and ready on the same edge while dout is valid
        threshold = 69'd10;
        @(negedge clk);
        ready     = 1'b0;
        din       = 64'd2;
        din_valid = 1'b1;
        @(negedge clk);
        ready     = 1'b1;
        din       = 64'd4;
        @(negedge clk);
        din_valid = 1'b0;
        ready     = 1'b0;
        chk("same_edge_dout", dout, 10);
        chk("same_edge_valid", 69'(dout_valid), 1);
        chk("same_edge_over", 69'(over_thresh), 1);
        chk("same_edge_overrun", 69'(overrun), 0);

        // Default parameters, full-scale samples
        big_exp = 69'd32 * 69'(64'h7FFF_FFFF_FFFF_FFFF);
        @(negedge clk);
        b_threshold = big_exp;
        b_din       = 64'h7FFF_FFFF_FFFF_FFFF;
        b_din_valid = 1'b1;
        repeat (31) @(negedge clk);
        chk("big_valid_early", 69'(b_dout_valid), 0);
        @(negedge clk);
        b_din_valid = 1'b0;
        chk("big_dout", b_dout, big_exp);
        chk("big_valid", 69'(b_dout_valid), 1);
        chk("big_over", 69'(b_over_thresh), 1);
        @(negedge clk);
        b_din       = 64'd0;
        b_din_valid = 1'b1;
        @(negedge clk);
        b_din_valid = 1'b0;
        chk("big_slide", b_dout, big_exp - 69'(64'h7FFF_FFFF_FFFF_FFFF));
        chk("big_over_drop", 69'(b_over_thresh), 0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
